// File: rtl/bcd_display_scanner.sv
// Collects a serial (digit, place) stream into a 3-digit frame and scans it
// onto a shared 7-segment bus with per-digit selects and a dead time per slot.
module bcd_display_scanner #(
    parameter int SCAN_POW2          = 4,
    parameter int BLANK_CYCLES       = 2,
    parameter int LEADING_ZERO_BLANK = 1,
    parameter int SEG_ACTIVE_LOW     = 0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] digit,
    input  logic [1:0] digit_place,
    output logic [6:0] segments,
    output logic [2:0] digit_select,
    output logic       frame_valid
);

    localparam logic [SCAN_POW2-1:0] SCAN_MAX = '1;
    localparam logic [SCAN_POW2-1:0] BLANK_N  = SCAN_POW2'(BLANK_CYCLES);

    logic [3:0]           shadow [3];
    logic [3:0]           display [3];
    logic [2:0]           written_mask;
    logic [2:0]           mask_next;
    logic [1:0]           prev_place;
    logic [1:0]           slot;
    logic [SCAN_POW2-1:0] scan_count;
    logic                 commit;
    logic                 frame_edge;

    logic [3:0] cur;
    logic       blanked;
    logic       dark;
    logic [6:0] seg_raw;
    logic [2:0] sel_raw;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // A units -> hundreds step marks a frame boundary, complete or not
    assign frame_edge = (prev_place == 2'd0) && (digit_place == 2'd2);
    assign commit     = frame_edge && (written_mask == 3'b111);

    always_comb begin
        mask_next = written_mask;
        if (frame_edge) begin
            mask_next = 3'b000;
        end
        for (int i = 0; i < 3; i++) begin
            if (digit_place == 2'(i)) begin
                mask_next[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                shadow[i]  <= 4'd0;
                display[i] <= 4'd0;
            end
            written_mask <= 3'b000;
            prev_place   <= 2'd3;
            slot         <= 2'd0;
            scan_count   <= '0;
            frame_valid  <= 1'b0;
        end else begin
            prev_place   <= digit_place;
            written_mask <= mask_next;
            for (int i = 0; i < 3; i++) begin
                if (digit_place == 2'(i)) begin
                    shadow[i] <= digit;
                end
            end
            if (commit) begin
                for (int i = 0; i < 3; i++) begin
                    display[i] <= shadow[i];
                end
                frame_valid <= 1'b1;
            end
            scan_count <= scan_count + 1'b1;
            if (slot == 2'd3) begin
                slot <= 2'd0;
            end else if (scan_count == SCAN_MAX) begin
                slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            end
        end
    end

    always_comb begin
        cur     = display[0];
        blanked = 1'b0;
        seg_raw = 7'h00;
        sel_raw = 3'b000;
        case (slot)
            2'd1: begin
                cur     = display[1];
                blanked = (LEADING_ZERO_BLANK != 0) &&
                          (display[2] == 4'd0) && (display[1] == 4'd0);
            end
            2'd2: begin
                cur     = display[2];
                blanked = (LEADING_ZERO_BLANK != 0) && (display[2] == 4'd0);
            end
            default: cur = display[0];
        endcase
        dark = (scan_count < BLANK_N) || !frame_valid || blanked ||
               (slot == 2'd3);
        if (!dark) begin
            sel_raw = 3'b001 << slot;
            seg_raw = decode(cur);
        end
        segments     = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        digit_select = (SEG_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised bench for bcd_display_scanner against a frame/scan reference model.
// A second instance covers the no-blanking, active-low output options.
module tb_bcd_display_scanner;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [1:0] digit_place = 2'd3;
    logic [6:0] segments, segments_alt;
    logic [2:0] digit_select, digit_select_alt;
    logic       frame_valid, frame_valid_alt;

    bcd_display_scanner dut (
        .clock(clock), .reset_n(reset_n), .digit(digit),
        .digit_place(digit_place), .segments(segments),
        .digit_select(digit_select), .frame_valid(frame_valid)
    );

    bcd_display_scanner #(
        .LEADING_ZERO_BLANK(0), .SEG_ACTIVE_LOW(1)
    ) dut_alt (
        .clock(clock), .reset_n(reset_n), .digit(digit),
        .digit_place(digit_place), .segments(segments_alt),
        .digit_select(digit_select_alt), .frame_valid(frame_valid_alt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int p;
        int d;
    } step_t;

    step_t seq[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frame collector plus time-based scan position
    int m_sh[3];
    int m_disp[3];
    bit m_got[3];
    int m_prev;
    bit m_fv;
    int m_cyc;

    function automatic logic [6:0] dec(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return (d > 9) ? 7'h40 : tbl[d];
    endfunction

    function automatic logic [10:0] exp_out(input bit lzb, input bit inv);
        int pos, s, d;
        bit blank, is_dark;
        logic [6:0] seg;
        logic [2:0] sel;
        pos = m_cyc % 16;
        s = (m_cyc / 16) % 3;
        d = m_disp[s];
        blank = lzb && ((s == 2 && d == 0) ||
                (s == 1 && m_disp[2] == 0 && m_disp[1] == 0));
        is_dark = (pos < 2) || !m_fv || blank;
        seg = is_dark ? 7'h00 : dec(d);
        sel = is_dark ? 3'b000 : 3'(1 << s);
        if (inv) begin
            seg = ~seg;
            sel = ~sel;
        end
        return {seg, sel, m_fv};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_sh[i] = 0;
            m_disp[i] = 0;
            m_got[i] = 0;
        end
        m_prev = 3;
        m_fv = 0;
        m_cyc = 0;
    endtask

    task automatic model_step(input int p, input int d);
        if (m_prev == 0 && p == 2) begin
            if (m_got[0] && m_got[1] && m_got[2]) begin
                m_disp = m_sh;
                m_fv = 1;
            end
            m_got = '{0, 0, 0};
        end
        if (p <= 2) begin
            m_sh[p] = d;
            m_got[p] = 1;
        end
        m_prev = p;
        m_cyc++;
    endtask

    // Applies one clock of input; called at a negedge, returns at the next
    task automatic drive(input int p, input int d);
        digit_place = p[1:0];
        digit = d[3:0];
        @(posedge clock);
        model_step(p, d);
        @(negedge clock);
    endtask

    task automatic push_frame(input int h, input int t, input int u,
                              input int len);
        for (int i = 0; i < len; i++) seq.push_back('{2, h});
        for (int i = 0; i < len; i++) seq.push_back('{1, t});
        for (int i = 0; i < len; i++) seq.push_back('{0, u});
        seq.push_back('{2, h});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) seq.push_back('{3, 0});
    endtask

    task automatic sync_reset_cycle();
        @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [10:0] e, a;
        model_reset();
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({segments, digit_select, frame_valid} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_main got=%h exp=000",
                     {segments, digit_select, frame_valid});
        end
        n_cmp++;
        if ({segments_alt, digit_select_alt, frame_valid_alt} !== 11'h7FE) begin
            n_err++;
            $display("FAIL reset_alt got=%h exp=7fe",
                     {segments_alt, digit_select_alt, frame_valid_alt});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive(3, $urandom_range(0, 15));
            e = exp_out(1, 0);
            a = exp_out(0, 1);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e ||
                {segments, digit_select, frame_valid} !== 11'h0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
            n_cmp++;
            if ({segments_alt, digit_select_alt, frame_valid_alt} !== a) begin
                n_err++;
                $display("FAIL reset_idle_alt cyc=%0d got=%h exp=%h", m_cyc,
                         {segments_alt, digit_select_alt, frame_valid_alt}, a);
            end
        end
    endtask

    task automatic test_frame();
        logic [10:0] e, a;
        int act[3];
        act = '{0, 0, 0};
        seq.delete();
        push_frame(1, 2, 3, 8);
        push_idle(60);
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            a = exp_out(0, 1);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e) begin
                n_err++;
                $display("FAIL frame cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
            n_cmp++;
            if ({segments_alt, digit_select_alt, frame_valid_alt} !== a) begin
                n_err++;
                $display("FAIL frame_alt cyc=%0d got=%h exp=%h", m_cyc,
                         {segments_alt, digit_select_alt, frame_valid_alt}, a);
            end
            if (digit_select == 3'b001 && segments == 7'h4F) act[0]++;
            if (digit_select == 3'b010 && segments == 7'h5B) act[1]++;
            if (digit_select == 3'b100 && segments == 7'h06) act[2]++;
        end
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_err++;
            $display("FAIL frame_valid got=%b exp=1", frame_valid);
        end
        n_cmp++;
        if (act[0] < 14 || act[1] < 14 || act[2] < 14) begin
            n_err++;
            $display("FAIL frame_active got=%0d/%0d/%0d exp>=14 each",
                     act[0], act[1], act[2]);
        end
    endtask

    task automatic test_blanking();
        logic [10:0] e, a;
        seq.delete();
        push_frame(0, 0, 7, 3);
        push_idle(50);
        push_frame(0, 0, 0, 2);
        push_idle(50);
        push_frame(0, 3, 0, 2);
        push_idle(50);
        push_frame(4, 0, 0, 2);
        push_idle(50);
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            a = exp_out(0, 1);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e) begin
                n_err++;
                $display("FAIL blank cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
            n_cmp++;
            if ({segments_alt, digit_select_alt, frame_valid_alt} !== a) begin
                n_err++;
                $display("FAIL blank_alt cyc=%0d got=%h exp=%h", m_cyc,
                         {segments_alt, digit_select_alt, frame_valid_alt}, a);
            end
        end
    endtask

    task automatic test_illegal();
        logic [10:0] e, a;
        seq.delete();
        push_frame(5, 12, 4, 4);
        push_idle(50);
        push_frame(0, 10, 15, 1);
        push_idle(50);
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            a = exp_out(0, 1);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e) begin
                n_err++;
                $display("FAIL illegal cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
            n_cmp++;
            if ({segments_alt, digit_select_alt, frame_valid_alt} !== a) begin
                n_err++;
                $display("FAIL illegal_alt cyc=%0d got=%h exp=%h", m_cyc,
                         {segments_alt, digit_select_alt, frame_valid_alt}, a);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] e;
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({segments, digit_select, frame_valid} !== 11'h0) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=000",
                     {segments, digit_select, frame_valid});
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        seq.delete();
        for (int i = 0; i < 3; i++) seq.push_back('{2, 8});
        for (int i = 0; i < 3; i++) seq.push_back('{1, 8});
        foreach (seq[k]) drive(seq[k].p, seq[k].d);
        sync_reset_cycle();
        seq.delete();
        for (int i = 0; i < 3; i++) seq.push_back('{0, 8});
        seq.push_back('{2, 8});
        push_idle(40);
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e ||
                frame_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midframe cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
        end
        seq.delete();
        push_frame(9, 8, 6, 2);
        push_idle(50);
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e) begin
                n_err++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
        end
        n_cmp++;
        if (frame_valid !== 1'b1) begin
            n_err++;
            $display("FAIL recommit got=%b exp=1", frame_valid);
        end
    endtask

    task automatic test_random();
        logic [10:0] e, a;
        int p;
        seq.delete();
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 6; i++) begin
                    p = $urandom_range(0, 3);
                    seq.push_back('{p, $urandom_range(0, 15)});
                end
            end else begin
                push_frame($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(1, 5));
            end
            push_idle($urandom_range(0, 30));
        end
        foreach (seq[k]) begin
            drive(seq[k].p, seq[k].d);
            e = exp_out(1, 0);
            a = exp_out(0, 1);
            n_cmp++;
            if ({segments, digit_select, frame_valid} !== e) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%h exp=%h", m_cyc,
                         {segments, digit_select, frame_valid}, e);
            end
            n_cmp++;
            if ({segments_alt, digit_select_alt, frame_valid_alt} !== a) begin
                n_err++;
                $display("FAIL random_alt cyc=%0d got=%h exp=%h", m_cyc,
                         {segments_alt, digit_select_alt, frame_valid_alt}, a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_blanking();
        test_illegal();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
